rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one 8-to-3 encoded resource slot between 8 requesters.
- Issues a registered one-hot grant plus its 3-bit encoded index and a valid flag.
- Downstream logic uses the index to select the owning requester's data.
- Bounds ownership with a hold limit so a requester that keeps its request high cannot starve the others.

Parameters:
MAX_HOLD, 4, maximum consecutive grant cycles for one owner while another request is pending; legal range 1..15
CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
req  input  8  request vector; bit k = requester k wants the resource; level-sensitive
grant  output  8  registered one-hot grant; all-zero when idle
grant_idx  output  3  binary index of the set grant bit; 0 when idle
grant_valid  output  1  high when any grant bit is set
hold_cnt  output  CNT_W  cycles the current owner has held the grant, 0 on first grant cycle

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset (rst high at a clock edge), which overrides all other inputs:
  - grant=8'h00, grant_idx=0, grant_valid=0, hold_cnt=0.
  - Internal ptr=0 (requester 0 has highest priority); state=IDLE.
- Reset mid-grant drops the grant on the next edge, with no release handshake.
- All outputs are registered. grant_idx and grant_valid always match grant in the same cycle.
- Search function: pick(v, p) returns the first set bit of v scanning p, p+1, ..., 7, 0, ..., p-1 (mod-8 wrap).
- State IDLE (grant=0):
  - If req!=0, next state GRANT with owner k=pick(req, ptr).
  - Latency: req sampled at edge N, grant visible after edge N.
  - On entry: hold_cnt=0, ptr=(k+1) mod 8.
- State GRANT, owner k. The rules below are evaluated on each edge in priority order:
  1. Release. req[k]==0:
     - others = req with bit k cleared.
     - If others!=0, hand over directly to k2=pick(others, ptr) with no idle bubble; hold_cnt=0, ptr=(k2+1) mod 8.
     - Otherwise go to IDLE and clear grant.
  2. Preempt. req[k]==1, hold_cnt==MAX_HOLD-1 and others!=0: hand over to pick(others, ptr) exactly as in rule 1.
  3. Continue. Otherwise keep owner k.
     - hold_cnt increments, saturating at MAX_HOLD-1.
     - If no other request is pending, a saturated owner keeps the grant indefinitely.
- The grant output never has more than one bit set, and is never zero while state=GRANT.
- ptr wraps 7→0. A granted requester goes to lowest priority for the next decision.
- Simultaneous events:
  - Owner release and new requests on the same edge: use rule 1; the new requests are eligible.
  - A request that rises on the same edge the owner is preempted is eligible for that handover.
- Requests are not latched. A request that drops before it is granted is lost. No X-propagation from req while rst is high.

Test Plan:
1. Reset, then req=8'h00 for 3 cycles -> grant=0, grant_idx=0, grant_valid=0, hold_cnt=0 throughout.
2. From reset, req=8'b0001_0100 held:
   - Cycle 1: grant=8'h04, idx=2.
   - After MAX_HOLD=4 grant cycles (hold_cnt 0..3): grant=8'h10, idx=4.
   - After another 4 cycles: grant returns to idx=2.
3. req=8'hFF with each owner dropping its bit 1 cycle after being granted -> owners 0,1,...,7,0 in order, no grant_valid gaps, hold_cnt=0 on each handover.
4. Owner 7 granted and releases while req[0] rises on the same edge -> next grant=8'h01, idx=0; verifies ptr wrap 7→0.
5. Only req[3] high for 20 cycles -> grant=8'h08 continuously, hold_cnt saturates at 3, no preemption. Then req[5] rises -> grant=8'h20 one cycle later.
6. rst asserted during GRANT with owner 6 -> next edge grant=0, hold_cnt=0. With req=8'h41 held after reset, the first grant goes to idx=0 (ptr reset).

Source files
------------

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with a bounded hold time per owner.
// Grant, encoded index, valid flag and hold counter are all registered.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       req,
    output logic [7:0]       grant,
    output logic [2:0]       grant_idx,
    output logic             grant_valid,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           r_state;
    logic [2:0]       r_ptr;
    logic [7:0]       r_grant;
    logic [2:0]       r_grant_idx;
    logic             r_grant_valid;
    logic [CNT_W-1:0] r_hold;

    logic [7:0] w_others;
    logic       w_owner_req;
    logic [7:0] w_cand;
    logic [3:0] w_pick;
    logic       w_switch;

    // First set bit of v scanning p, p+1, ... with wrap; result is {found, index}.
    function automatic logic [3:0] pick(input logic [7:0] v, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] k;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            k = p + 3'(i);
            if (v[k]) begin
                res = {1'b1, k};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Candidate selection: from IDLE any request competes, while granted only the others do.
    always_comb begin
        w_others    = req & ~r_grant;
        w_owner_req = |(req & r_grant);
        w_cand      = (r_state == ST_GRANT) ? w_others : req;
        w_pick      = pick(w_cand, r_ptr);
        w_switch    = (r_state != ST_GRANT) || !w_owner_req ||
                      ((r_hold == HOLD_LAST) && (|w_others));
    end

    // Arbitration state and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_ptr         <= 3'd0;
            r_grant       <= 8'h00;
            r_grant_idx   <= 3'd0;
            r_grant_valid <= 1'b0;
            r_hold        <= '0;
        end else if (w_switch && w_pick[3]) begin
            r_state       <= ST_GRANT;
            r_ptr         <= w_pick[2:0] + 3'd1;
            r_grant       <= 8'h01 << w_pick[2:0];
            r_grant_idx   <= w_pick[2:0];
            r_grant_valid <= 1'b1;
            r_hold        <= '0;
        end else if (w_switch) begin
            r_state       <= ST_IDLE;
            r_grant       <= 8'h00;
            r_grant_idx   <= 3'd0;
            r_grant_valid <= 1'b0;
            r_hold        <= '0;
        end else if (r_hold != HOLD_LAST) begin
            r_hold        <= r_hold + CNT_W'(1);
        end else begin
            r_hold        <= r_hold;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign hold_cnt    = r_hold;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios plus randomized
// requests, all compared against an integer-level round-robin model.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 4;

    logic             clk;
    logic             rst;
    logic [7:0]       req;
    logic [7:0]       grant;
    logic [2:0]       grant_idx;
    logic             grant_valid;
    logic [CNT_W-1:0] hold_cnt;

    int n_vec;
    int n_bad;

    // model state: owner -1 means idle
    int m_owner;
    int m_ptr;
    int m_hold;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .hold_cnt    (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mpick(input logic [7:0] v, input int p);
        for (int i = 0; i < 8; i++) begin
            if (v[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [7:0] others;
        int k;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0;
        end else if (m_owner < 0) begin
            k = mpick(req, m_ptr);
            if (k >= 0) begin
                m_owner = k; m_hold = 0; m_ptr = (k + 1) % 8;
            end
        end else begin
            others = req;
            others[m_owner] = 1'b0;
            if (!req[m_owner] || (m_hold == MAX_HOLD - 1 && others != 8'h00)) begin
                k = mpick(others, m_ptr);
                if (k >= 0) begin
                    m_owner = k; m_hold = 0; m_ptr = (k + 1) % 8;
                end else begin
                    m_owner = -1; m_hold = 0;
                end
            end else if (m_hold < MAX_HOLD - 1) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    function automatic logic [15:0] exp_vec();
        logic [7:0] g;
        logic [2:0] ix;
        g  = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        ix = (m_owner < 0) ? 3'd0 : 3'(m_owner);
        return {g, ix, (m_owner >= 0), 4'(m_hold)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'hFF;
        tick();
        rst = 1'b0; req = 8'h00;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if ({grant, grant_idx, grant_valid, hold_cnt} !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_idle c=%0d got g=%h i=%0d v=%b h=%0d want all zero",
                         c, grant, grant_idx, grant_valid, hold_cnt);
            end
        end
    endtask

    task automatic test_preempt();
        logic [7:0] eg;
        do_reset();
        req = 8'b0001_0100;
        for (int c = 0; c < 9; c++) begin
            tick();
            eg = (c < 4 || c >= 8) ? 8'h04 : 8'h10;
            n_vec++;
            if (grant !== eg || hold_cnt !== 4'(c % 4) || grant_valid !== 1'b1 ||
                {grant, grant_idx, grant_valid, hold_cnt} !== exp_vec()) begin
                n_bad++;
                $display("FAIL preempt c=%0d got g=%h i=%0d h=%0d want g=%h h=%0d",
                         c, grant, grant_idx, hold_cnt, eg, c % 4);
            end
        end
    endtask

    task automatic test_sequential_release();
        do_reset();
        req = 8'hFF;
        for (int c = 0; c < 9; c++) begin
            tick();
            n_vec++;
            if (grant !== (8'h01 << (c % 8)) || grant_idx !== 3'(c % 8) ||
                grant_valid !== 1'b1 || hold_cnt !== 4'd0 ||
                {grant, grant_idx, grant_valid, hold_cnt} !== exp_vec()) begin
                n_bad++;
                $display("FAIL seq_release c=%0d got g=%h i=%0d v=%b h=%0d want idx=%0d h=0",
                         c, grant, grant_idx, grant_valid, hold_cnt, c % 8);
            end
            req = 8'hFF & ~(8'h01 << (c % 8));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 8'h80;
        tick();
        req = 8'h01;
        tick();
        n_vec++;
        if (grant !== 8'h01 || grant_idx !== 3'd0 || grant_valid !== 1'b1 ||
            {grant, grant_idx, grant_valid, hold_cnt} !== exp_vec()) begin
            n_bad++;
            $display("FAIL wrap got g=%h i=%0d want g=01 i=0", grant, grant_idx);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        req = 8'h08;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_vec++;
            if (grant !== 8'h08 || hold_cnt !== 4'((c < 3) ? c : 3) ||
                {grant, grant_idx, grant_valid, hold_cnt} !== exp_vec()) begin
                n_bad++;
                $display("FAIL saturate c=%0d got g=%h h=%0d want g=08 h=%0d",
                         c, grant, hold_cnt, (c < 3) ? c : 3);
            end
        end
        req = 8'h28;
        tick();
        n_vec++;
        if (grant !== 8'h20 || grant_idx !== 3'd5 || hold_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL saturate_handover got g=%h i=%0d h=%0d want g=20 i=5 h=0",
                     grant, grant_idx, hold_cnt);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 8'h40;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        n_vec++;
        if (grant !== 8'h00 || hold_cnt !== 4'd0 || grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_mid got g=%h i=%0d v=%b h=%0d want zero",
                     grant, grant_idx, grant_valid, hold_cnt);
        end
        rst = 1'b0; req = 8'h41;
        tick();
        n_vec++;
        if (grant !== 8'h01 || grant_idx !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_ptr got g=%h i=%0d want g=01 i=0", grant, grant_idx);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 7)] = 1'b0;
            rst = ($urandom_range(0, 79) == 0);
            tick();
            n_vec++;
            if ({grant, grant_idx, grant_valid, hold_cnt} !== exp_vec() ||
                $countones(grant) > 1) begin
                n_bad++;
                $display("FAIL random c=%0d req=%h got g=%h i=%0d v=%b h=%0d want %h",
                         c, req, grant, grant_idx, grant_valid, hold_cnt, exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        m_owner = -1; m_ptr = 0; m_hold = 0;
        rst = 1'b1; req = 8'h00;
        test_reset();
        test_preempt();
        test_sequential_release();
        test_wrap();
        test_saturate();
        test_reset_mid_grant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
